// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared FSM state encoding, default widths and alu control codes.
package alu_sched_pkg;

    localparam int unsigned DefW  = 8;
    localparam int unsigned DefCw = 4;

    // ALU control codes; any other code yields zero.
    localparam int unsigned CtrAdd = 0;
    localparam int unsigned CtrSub = 1;
    localparam int unsigned CtrAnd = 2;
    localparam int unsigned CtrOr  = 3;
    localparam int unsigned CtrXor = 4;
    localparam int unsigned CtrShl = 5;
    localparam int unsigned CtrShr = 6;
    localparam int unsigned CtrNot = 7;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/alu_sched_alu.sv
// alu: single-cycle ALU with a registered result, shared by the scheduler.
module alu
    import alu_sched_pkg::*;
#(
    parameter int unsigned W  = DefW,
    parameter int unsigned CW = DefCw
) (
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    output logic [W-1:0]  O,
    input  logic [CW-1:0] CTR,
    input  logic          ck
);

    // Result register; left unreset because the scheduler masks it until a response is valid.
    always_ff @(posedge ck) begin
        case (CTR)
            CW'(CtrAdd): O <= A + B;
            CW'(CtrSub): O <= A - B;
            CW'(CtrAnd): O <= A & B;
            CW'(CtrOr):  O <= A | B;
            CW'(CtrXor): O <= A ^ B;
            CW'(CtrShl): O <= A << 1;
            CW'(CtrShr): O <= A >> 1;
            CW'(CtrNot): O <= ~A;
            default:     O <= '0;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler time-sharing one registered alu between two requesters.
// Optional feature: define ALU_SCHED_CNT_EN to add per-port accept counters cnt0/cnt1.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned W  = DefW,
    parameter int unsigned CW = DefCw
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic [CW-1:0] req0_ctr,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [W-1:0]  rsp0_o,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    input  logic [CW-1:0] req1_ctr,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [W-1:0]  rsp1_o
`ifdef ALU_SCHED_CNT_EN
    ,
    output logic [7:0]    cnt0,
    output logic [7:0]    cnt1
`endif
);

    state_e        r_state;
    logic          r_last;   // 1: port 1 was granted last
    logic          r_owner;  // port owning the in-flight operation
    logic          r_rsp0_valid;
    logic          r_rsp1_valid;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [CW-1:0] r_ctr;

    logic          w_idle;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_accept;
    logic [W-1:0]  w_alu_o;

    alu #(
        .W  (W),
        .CW (CW)
    ) alu (
        .A   (r_a),
        .B   (r_b),
        .O   (w_alu_o),
        .CTR (r_ctr),
        .ck  (ck)
    );

    // Arbitration, handshake outputs and result masking; everything is forced low in reset.
    always_comb begin
        w_idle     = rst_n && (r_state == StIdle);
        w_grant1   = req1_valid && (!req0_valid || !r_last);
        w_grant0   = req0_valid && !w_grant1;
        w_accept   = w_idle && (w_grant0 || w_grant1);
        req0_ready = w_idle && w_grant0;
        req1_ready = w_idle && w_grant1;
        rsp0_valid = rst_n && r_rsp0_valid;
        rsp1_valid = rst_n && r_rsp1_valid;
        rsp0_o     = rsp0_valid ? w_alu_o : '0;
        rsp1_o     = rsp1_valid ? w_alu_o : '0;
    end

    // Scheduler FSM: accept -> one exec cycle for the alu to sample -> hold response.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_ctr        <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_a     <= w_grant1 ? req1_a : req0_a;
                        r_b     <= w_grant1 ? req1_b : req0_b;
                        r_ctr   <= w_grant1 ? req1_ctr : req0_ctr;
                        r_owner <= w_grant1;
                        r_last  <= w_grant1;
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    r_rsp0_valid <= !r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= StResp;
                end
                StResp: begin
                    if (r_owner ? rsp1_ready : rsp0_ready) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef ALU_SCHED_CNT_EN
    logic [7:0] r_cnt0;
    logic [7:0] r_cnt1;

    // Per-port accept counters, wrapping naturally at 8 bits.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_cnt0 <= 8'd0;
            r_cnt1 <= 8'd0;
        end else if (w_accept) begin
            if (w_grant1) begin
                r_cnt1 <= r_cnt1 + 8'd1;
            end else begin
                r_cnt0 <= r_cnt0 + 8'd1;
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule
